mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single external memory port between instruction fetch (IF) and
//  the MEM stage (load/store). Serializes one transaction at a time, with MEM
//  priority and a starvation guard for IF. Drives stall_req so the pipeline
//  control logic can freeze the IF/ID..EX/MEM registers while a MEM access is pending.
// PARAMETERS
//  ADDR_W      32  address width, byte address
//  DATA_W      32  data width; byte lanes = DATA_W/8
//  STARVE_MAX  4   consecutive MEM grants with IF pending before IF is forced next
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  rst        in   1         asynchronous, active-high reset
//  if_req     in   1         IF read request; held with if_addr until if_done
//  if_addr    in   ADDR_W    fetch address
//  if_rdata   out  DATA_W    fetched word; valid while if_done=1
//  if_done    out  1         1-cycle completion pulse for IF
//  mem_req    in   1         MEM request; held with mem_* inputs until mem_done
//  mem_we     in   1         1=store, 0=load
//  mem_addr   in   ADDR_W    load/store address
//  mem_wdata  in   DATA_W    store data
//  mem_sel    in   DATA_W/8  byte-lane enables
//  mem_rdata  out  DATA_W    load data; valid while mem_done=1
//  mem_done   out  1         1-cycle completion pulse for MEM
//  ram_req    out  1         memory command valid; held until ram_ready
//  ram_we     out  1         command is a write
//  ram_addr   out  ADDR_W    command address
//  ram_wdata  out  DATA_W    write data
//  ram_sel    out  DATA_W/8  byte enables (all-ones for IF)
//  ram_ready  in   1         command accepted in a cycle where ram_req=1
//  ram_rvalid in   1         response (read data or write ack), 1 cycle
//  ram_rdata  in   DATA_W    read data, valid with ram_rvalid
//  stall_req  out  1         = mem_req & ~mem_done (combinational)
// BEHAVIOUR
//  - Reset (async): state=IDLE, starve cnt=0, owner=IF; all ram_*, *_done,
//    *_rdata outputs = 0. An in-flight transaction is abandoned; a ram_rvalid
//    arriving after reset is ignored.
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: sample requests. If both are pending: MEM wins unless cnt==STARVE_MAX,
//    in which case IF wins. Latch owner, addr, we, wdata, sel into regs; go to
//    ISSUE. No request: stay in IDLE.
//  - Counter: reset to 0 on an IF grant; +1 on a MEM grant while if_req=1,
//    saturating at STARVE_MAX; unchanged on a MEM grant while if_req=0.
//  - ISSUE: ram_req=1 with registered fields (IF: we=0, sel=all-ones,
//    wdata=0). On ram_ready: go to WAIT, ram_req=0 next cycle. Stay in ISSUE
//    otherwise. ram_rvalid is ignored here.
//  - WAIT: on ram_rvalid, register ram_rdata and go to RESP.
//  - RESP: pulse the owner's done for exactly one cycle, with rdata valid
//    (rdata undefined for stores; drive 0). Then go to IDLE. Requests are not
//    sampled in RESP, so a req dropped in reaction to done is never re-granted.
//  - Min latency: req seen at cycle 0; ram_req at 1; ready at 1; rvalid at 2;
//    done at 3. Throughput: at most one transaction per 4 cycles.
//  - Non-owner req held during a transaction: queued; no done, no effect.
//  - Requester drops req before done: the transaction still completes and done
//    still pulses (illegal per protocol; no recovery required).
//  - ram_ready and ram_rvalid in the same cycle while in ISSUE: accept only;
//    this rvalid is lost (the memory must respond at least 1 cycle after accept).
// TESTING
//  1 Reset mid-WAIT: rst pulse, then ram_rvalid=1 -> no done; all outputs 0;
//    next if_req grants normally.
//  2 Lone IF read 0x100, ready immediate, rdata=0xDEADBEEF one cycle later ->
//    if_done at cycle 3, if_rdata=0xDEADBEEF, ram_sel=4'hF, ram_we=0.
//  3 Simultaneous if_req+mem_req (store 0x200, sel=4'b0011) -> MEM served
//    first (ram_we=1), stall_req=1 until mem_done, then IF served.
//  4 mem_req held continuously with if_req high, STARVE_MAX=4 -> grant order
//    M,M,M,M,I,M...
//  5 ram_ready low for 5 cycles -> ram_req and fields stable for all 5 cycles,
//    single accept, single done.
//  6 Done-pulse check: if_req held 1 cycle past if_done -> no second fetch issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory port arbiter: shares one external memory port between instruction
// fetch (IF) and the MEM stage. One transaction at a time, MEM has priority,
// and a starvation counter forces an IF grant after STARVE_MAX consecutive
// MEM grants taken while IF was waiting.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | sample requests, pick owner, latch command fields
// S_ISSUE | drive ram_req with latched fields until ram_ready
// S_WAIT  | command accepted, waiting for ram_rvalid
// S_RESP  | pulse owner's done with registered read data
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic [DATA_W-1:0]     o_if_rdata,
    output logic                  o_if_done,
    input  logic                  i_mem_req,
    input  logic                  i_mem_we,
    input  logic [ADDR_W-1:0]     i_mem_addr,
    input  logic [DATA_W-1:0]     i_mem_wdata,
    input  logic [DATA_W/8-1:0]   i_mem_sel,
    output logic [DATA_W-1:0]     o_mem_rdata,
    output logic                  o_mem_done,
    output logic                  o_ram_req,
    output logic                  o_ram_we,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic [DATA_W-1:0]     o_ram_wdata,
    output logic [DATA_W/8-1:0]   o_ram_sel,
    input  logic                  i_ram_ready,
    input  logic                  i_ram_rvalid,
    input  logic [DATA_W-1:0]     i_ram_rdata,
    output logic                  o_stall_req
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner_mem;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_starved;
    logic                w_grant_if;
    logic                w_grant_mem;

    // IF wins when it is alone or when MEM has starved it long enough
    assign w_starved   = (r_cnt == CNT_W'(STARVE_MAX));
    assign w_grant_if  = (r_state == S_IDLE) && i_if_req && (!i_mem_req || w_starved);
    assign w_grant_mem = (r_state == S_IDLE) && i_mem_req && !w_grant_if;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and output decode
    always_comb begin
        w_next      = r_state;
        o_ram_req   = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_ram_sel   = '0;
        o_if_done   = 1'b0;
        o_if_rdata  = '0;
        o_mem_done  = 1'b0;
        o_mem_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_if || w_grant_mem) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                o_ram_req   = 1'b1;
                o_ram_we    = r_we;
                o_ram_addr  = r_addr;
                o_ram_wdata = r_wdata;
                o_ram_sel   = r_sel;
                // an rvalid coinciding with the accept is dropped on purpose
                if (i_ram_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_ram_rvalid) w_next = S_RESP;
            end
            S_RESP: begin
                if (r_owner_mem) begin
                    o_mem_done  = 1'b1;
                    o_mem_rdata = r_we ? '0 : r_rdata;
                end else begin
                    o_if_done   = 1'b1;
                    o_if_rdata  = r_rdata;
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, starvation counter and read-data capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner_mem <= 1'b0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_grant_if) begin
                r_owner_mem <= 1'b0;
                r_cnt       <= '0;
                r_addr      <= i_if_addr;
                r_we        <= 1'b0;
                r_wdata     <= '0;
                r_sel       <= '1;
            end else if (w_grant_mem) begin
                r_owner_mem <= 1'b1;
                if (i_if_req && !w_starved) r_cnt <= r_cnt + CNT_W'(1);
                r_addr      <= i_mem_addr;
                r_we        <= i_mem_we;
                r_wdata     <= i_mem_wdata;
                r_sel       <= i_mem_sel;
            end
            if (r_state == S_WAIT && i_ram_rvalid) r_rdata <= i_ram_rdata;
        end
    end

    assign o_stall_req = i_mem_req & ~o_mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-requester transactions plus
// hand-written sequences for reset, contention, starvation and pulse corners.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_sel;
    logic        ram_ready;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;
    logic        stall_req;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_done   (if_done),
        .i_mem_req   (mem_req),
        .i_mem_we    (mem_we),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .i_mem_sel   (mem_sel),
        .o_mem_rdata (mem_rdata),
        .o_mem_done  (mem_done),
        .o_ram_req   (ram_req),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .o_ram_sel   (ram_sel),
        .i_ram_ready (ram_ready),
        .i_ram_rvalid(ram_rvalid),
        .i_ram_rdata (ram_rdata),
        .o_stall_req (stall_req)
    );

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          ready_wait;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bounded wait for a command on the ram port; returns cycles waited
    task automatic wait_ram_req(input string name, output int cyc);
        cyc = 0;
        while (!ram_req && cyc < 20) begin
            step();
            cyc++;
        end
        chk(name, {31'd0, ram_req}, 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        int wcyc;
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.is_mem) begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr;
            mem_wdata = v.wdata; mem_sel = v.sel;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
            mem_wdata = v.wdata; mem_sel = v.sel;
        end
        wait_ram_req({tag, "_req"}, cyc);
        chk({tag, "_req_lat"}, cyc, 1);
        chk({tag, "_we"},    {31'd0, ram_we}, {31'd0, v.exp_we});
        chk({tag, "_addr"},  ram_addr, v.addr);
        chk({tag, "_wdata"}, ram_wdata, v.exp_wdata);
        chk({tag, "_sel"},   {28'd0, ram_sel}, {28'd0, v.exp_sel});
        chk({tag, "_stall"}, {31'd0, stall_req}, {31'd0, v.is_mem});
        for (int i = 0; i < v.ready_wait; i++) begin
            step();
            cyc++;
            chk({tag, "_hold_req"},  {31'd0, ram_req}, 32'd1);
            chk({tag, "_hold_addr"}, ram_addr, v.addr);
            chk({tag, "_hold_sel"},  {28'd0, ram_sel}, {28'd0, v.exp_sel});
        end
        ram_ready = 1'b1;
        step(); cyc++;
        ram_ready = 1'b0;
        chk({tag, "_req_drop"}, {31'd0, ram_req}, 32'd0);
        ram_rvalid = 1'b1; ram_rdata = v.rdata;
        step(); cyc++;
        ram_rvalid = 1'b0; ram_rdata = 32'h0;
        chk({tag, "_lat"}, cyc, v.exp_lat);
        if (v.is_mem) begin
            chk({tag, "_mem_done"}, {31'd0, mem_done}, 32'd1);
            chk({tag, "_if_done0"}, {31'd0, if_done}, 32'd0);
            chk({tag, "_mem_rdata"}, mem_rdata, v.exp_rdata);
            chk({tag, "_stall_off"}, {31'd0, stall_req}, 32'd0);
        end else begin
            chk({tag, "_if_done"}, {31'd0, if_done}, 32'd1);
            chk({tag, "_mem_done0"}, {31'd0, mem_done}, 32'd0);
            chk({tag, "_if_rdata"}, if_rdata, v.exp_rdata);
        end
        if_req = 1'b0; mem_req = 1'b0;
        step();
        wcyc = {31'd0, if_done | mem_done};
        chk({tag, "_done_pulse"}, wcyc, 0);
    endtask

    initial begin
        int cyc;
        logic exp_order[6];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        //          mem we   addr          wdata         sel    rw rdata         ewe   esel   ewdata        erdata        lat
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,       4'h0, 0, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0,        32'hDEAD_BEEF, 3};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 0, 32'hAAAA_AAAA, 1'b1, 4'h3, 32'h1234_5678, 32'h0,        3};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0000_0055, 4'hC, 0, 32'hCAFE_F00D, 1'b0, 4'hC, 32'h0000_0055, 32'hCAFE_F00D, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h9999_9999, 4'h1, 5, 32'h0BAD_CAFE, 1'b0, 4'hF, 32'h0,        32'h0BAD_CAFE, 8};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0308, 32'h0,       4'hF, 2, 32'h7654_3210, 1'b0, 4'hF, 32'h0,        32'h7654_3210, 5};

        rst = 1'b1;
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0;
        mem_wdata = 0; mem_sel = 0; ram_ready = 0; ram_rvalid = 0; ram_rdata = 0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_done", {30'd0, if_done, mem_done}, 32'd0);

        // Reset while waiting for a response; the late rvalid must be ignored
        if_req = 1'b1; if_addr = 32'h80;
        step();
        chk("mid_issue", {31'd0, ram_req}, 32'd1);
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0; if_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {ram_req, ram_we, if_done, mem_done, ram_sel, 24'd0}, 32'd0);
        step();
        rst = 1'b0;
        ram_rvalid = 1'b1; ram_rdata = 32'h1111_1111;
        step();
        ram_rvalid = 1'b0; ram_rdata = 0;
        chk("mid_no_done", {30'd0, if_done, mem_done}, 32'd0);
        chk("mid_rdata0", if_rdata, 32'd0);
        step();
        chk("mid_no_done2", {30'd0, if_done, mem_done}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Contention: MEM store first, IF queued behind it
        if_req = 1'b1; if_addr = 32'h140;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hA5A5_0F0F; mem_sel = 4'b0011;
        step();
        chk("con_m_we", {31'd0, ram_we}, 32'd1);
        chk("con_m_addr", ram_addr, 32'h200);
        chk("con_m_stall", {31'd0, stall_req}, 32'd1);
        ram_ready = 1'b1; step(); ram_ready = 1'b0;
        chk("con_m_stall_wait", {31'd0, stall_req}, 32'd1);
        ram_rvalid = 1'b1; ram_rdata = 32'h0; step(); ram_rvalid = 1'b0;
        chk("con_m_done", {30'd0, if_done, mem_done}, 32'd1);
        chk("con_m_stall_done", {31'd0, stall_req}, 32'd0);
        mem_req = 1'b0;
        step();
        chk("con_gap", {31'd0, ram_req}, 32'd0);
        step();
        chk("con_i_req", {31'd0, ram_req}, 32'd1);
        chk("con_i_addr", ram_addr, 32'h140);
        chk("con_i_sel", {28'd0, ram_sel}, 32'hF);
        ram_ready = 1'b1; step(); ram_ready = 1'b0;
        ram_rvalid = 1'b1; ram_rdata = 32'h0000_1357; step(); ram_rvalid = 1'b0;
        chk("con_i_done", {30'd0, if_done, mem_done}, 32'd2);
        chk("con_i_rdata", if_rdata, 32'h0000_1357);
        if_req = 1'b0;
        step();

        // Starvation guard: both held, expect M,M,M,M,I,M
        if_req = 1'b1; if_addr = 32'h500;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; mem_sel = 4'hF;
        for (int k = 0; k < 6; k++) begin
            wait_ram_req($sformatf("stv%0d_req", k), cyc);
            chk($sformatf("stv%0d_owner", k), {31'd0, ram_addr == 32'h400}, {31'd0, exp_order[k]});
            ram_ready = 1'b1; step(); ram_ready = 1'b0;
            ram_rvalid = 1'b1; ram_rdata = 32'(k); step(); ram_rvalid = 1'b0;
            chk($sformatf("stv%0d_done", k), {30'd0, if_done, mem_done},
                exp_order[k] ? 32'd1 : 32'd2);
            if (k == 5) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
            step();
        end

        // Accept and rvalid in the same ISSUE cycle: that rvalid is dropped
        if_req = 1'b1; if_addr = 32'h600;
        step();
        ram_ready = 1'b1; ram_rvalid = 1'b1; ram_rdata = 32'h22;
        step();
        ram_ready = 1'b0; ram_rvalid = 1'b0;
        step();
        chk("same_no_done", {31'd0, if_done}, 32'd0);
        ram_rvalid = 1'b1; ram_rdata = 32'h33;
        step();
        ram_rvalid = 1'b0;
        chk("same_done", {31'd0, if_done}, 32'd1);
        chk("same_rdata", if_rdata, 32'h33);
        if_req = 1'b0;
        step();

        // if_req held one cycle past done must not start another fetch
        if_req = 1'b1; if_addr = 32'h700;
        step();
        ram_ready = 1'b1; step(); ram_ready = 1'b0;
        ram_rvalid = 1'b1; ram_rdata = 32'h77; step(); ram_rvalid = 1'b0;
        chk("hold_done", {31'd0, if_done}, 32'd1);
        step();
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("hold_no_issue%0d", i), {30'd0, ram_req, if_done}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
